// File: rtl/cpu_ctrl_pkg.sv
// Shared types, opcode map and per-opcode helpers for the control sequencer.
// Optional build macro: ILLEGAL_TRAP_EN (undefined opcodes trap to HALT).
package cpu_ctrl_pkg;

    localparam int unsigned OPC_W  = 5;
    localparam int unsigned STEP_W = 3;

    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OPC_W-1:0] OP_JR   = 5'b10011;
    localparam logic [OPC_W-1:0] OP_IN   = 5'b10101;
    localparam logic [OPC_W-1:0] OP_OUT  = 5'b10110;
    localparam logic [OPC_W-1:0] OP_MFHI = 5'b10111;
    localparam logic [OPC_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11001;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11010;

    typedef enum logic [STEP_W-1:0] {T0, T1, T2, T3, T4, T5, T6, T7} step_e;

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_e;

    typedef struct packed {
        logic op_and;
        logic op_or;
        logic op_add;
        logic op_sub;
        logic op_mul;
        logic op_div;
        logic op_shr;
        logic op_shl;
        logic op_ror;
        logic op_rol;
        logic op_neg;
        logic op_not;
        logic op_inc_pc;
    } alu_t;

    typedef struct packed {
        logic pc_out;
        logic mdr_out;
        logic zhigh_out;
        logic zlow_out;
        logic hi_out;
        logic lo_out;
        logic inport_out;
        logic c_out;
        logic ba_out;
        logic pc_in;
        logic ir_in;
        logic mar_in;
        logic mdr_in;
        logic y_in;
        logic z_in;
        logic hi_in;
        logic lo_in;
        logic out_port;
        logic gra;
        logic grb;
        logic grc;
        logic rin;
        logic rout;
        logic read;
        logic write;
        alu_t alu;
    } ctrl_t;

    // Final execute step of each instruction; unknown opcodes behave as a one-step nop.
    function automatic step_e last_step(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_LD, OP_ST:                   last_step = T7;
            OP_MUL, OP_DIV, OP_BR:          last_step = T6;
            OP_NEG, OP_NOT:                 last_step = T4;
            OP_LDI, OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI:
                                            last_step = T5;
            default:                        last_step = T3;
        endcase
    endfunction

    function automatic logic is_defined(input logic [OPC_W-1:0] opc);
        case (opc)
            5'b10100, 5'b11011, 5'b11100, 5'b11101, 5'b11110, 5'b11111:
                     is_defined = 1'b0;
            default: is_defined = 1'b1;
        endcase
    endfunction

    // ALU line used by the operate step; address arithmetic for ld/ldi/st is an add.
    function automatic alu_t alu_of(input logic [OPC_W-1:0] opc);
        alu_t a;
        a = '0;
        case (opc)
            OP_AND, OP_ANDI:                       a.op_and = 1'b1;
            OP_OR, OP_ORI:                         a.op_or  = 1'b1;
            OP_ADD, OP_ADDI, OP_LDI, OP_LD, OP_ST: a.op_add = 1'b1;
            OP_SUB:                                a.op_sub = 1'b1;
            OP_MUL:                                a.op_mul = 1'b1;
            OP_DIV:                                a.op_div = 1'b1;
            OP_SHR:                                a.op_shr = 1'b1;
            OP_SHL:                                a.op_shl = 1'b1;
            OP_ROR:                                a.op_ror = 1'b1;
            OP_ROL:                                a.op_rol = 1'b1;
            OP_NEG:                                a.op_neg = 1'b1;
            OP_NOT:                                a.op_not = 1'b1;
            default:                               ;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from {opcode, step, CON} to the full datapath strobe vector.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opc,
    input  step_e            step,
    input  logic             con,
    output ctrl_t            ctrl
);

    always_comb begin
        ctrl = '0;
        case (step)
            T0: begin
                ctrl.pc_out        = 1'b1;
                ctrl.mar_in        = 1'b1;
                ctrl.alu.op_inc_pc = 1'b1;
                ctrl.z_in          = 1'b1;
            end
            T1: begin
                ctrl.zlow_out = 1'b1;
                ctrl.pc_in    = 1'b1;
                ctrl.read     = 1'b1;
                ctrl.mdr_in   = 1'b1;
            end
            T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            default: begin
                case (opc)
                    OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: begin
                        case (step)
                            T3: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1; end
                            T4: begin ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.alu = alu_of(opc); ctrl.z_in = 1'b1; end
                            T5: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_MUL, OP_DIV: begin
                        case (step)
                            T3: begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1; end
                            T4: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.alu = alu_of(opc); ctrl.z_in = 1'b1; end
                            T5: begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
                            T6: begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_NEG, OP_NOT: begin
                        case (step)
                            T3: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.alu = alu_of(opc); ctrl.z_in = 1'b1; end
                            T4: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (step)
                            T3: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1; end
                            T4: begin ctrl.c_out = 1'b1; ctrl.alu = alu_of(opc); ctrl.z_in = 1'b1; end
                            T5: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    // ldi, ld and st share the effective-address computation in T3-T4.
                    OP_LDI, OP_LD, OP_ST: begin
                        case (step)
                            T3: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
                            T4: begin ctrl.c_out = 1'b1; ctrl.alu = alu_of(opc); ctrl.z_in = 1'b1; end
                            T5: begin
                                ctrl.zlow_out = 1'b1;
                                if (opc == OP_LDI) begin
                                    ctrl.gra = 1'b1;
                                    ctrl.rin = 1'b1;
                                end else begin
                                    ctrl.mar_in = 1'b1;
                                end
                            end
                            T6: begin
                                ctrl.mdr_in = 1'b1;
                                if (opc == OP_LD) begin
                                    ctrl.read = 1'b1;
                                end else begin
                                    ctrl.gra  = 1'b1;
                                    ctrl.rout = 1'b1;
                                end
                            end
                            T7: begin
                                if (opc == OP_LD) begin
                                    ctrl.mdr_out = 1'b1;
                                    ctrl.gra     = 1'b1;
                                    ctrl.rin     = 1'b1;
                                end else begin
                                    ctrl.write = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (step)
                            T3: begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; end
                            T4: begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
                            T5: begin ctrl.c_out = 1'b1; ctrl.alu.op_add = 1'b1; ctrl.z_in = 1'b1; end
                            T6: begin ctrl.zlow_out = con; ctrl.pc_in = con; end
                            default: ;
                        endcase
                    end
                    OP_JR:   if (step == T3) begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pc_in = 1'b1; end
                    OP_IN:   if (step == T3) begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                    OP_OUT:  if (step == T3) begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.out_port = 1'b1; end
                    OP_MFHI: if (step == T3) begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                    OP_MFLO: if (step == T3) begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                    default: ;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: state, step counter, opcode latch and stop/halt logic.
// Optional build macro: ILLEGAL_TRAP_EN adds the sticky illegal_op output and traps undefined opcodes.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              stop,
    input  logic [31:0]       IR,
    input  logic              CON,
    output logic              PCout,
    output logic              MDRout,
    output logic              Zhighout,
    output logic              Zlowout,
    output logic              HIout,
    output logic              LOout,
    output logic              Inportout,
    output logic              Cout,
    output logic              BAout,
    output logic              PCin,
    output logic              IRin,
    output logic              MARin,
    output logic              MDRin,
    output logic              Yin,
    output logic              Zin,
    output logic              HIin,
    output logic              LOin,
    output logic              OutPort,
    output logic              Gra,
    output logic              Grb,
    output logic              Grc,
    output logic              Rin,
    output logic              Rout,
    output logic              read,
    output logic              write,
    output logic              AND,
    output logic              OR,
    output logic              ADD,
    output logic              SUB,
    output logic              MUL,
    output logic              DIV,
    output logic              SHR,
    output logic              SHL,
    output logic              ROR,
    output logic              ROL,
    output logic              NEG,
    output logic              NOT,
    output logic              IncPC,
    output logic              run,
    output logic [STEP_W-1:0] step
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic              illegal_op
`endif
);

    state_e           state_q, state_d;
    step_e            step_q, step_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic             stop_pend_q, stop_pend_d;
    logic [OPC_W-1:0] ir_opc_c;
    logic             trap_c;
    logic             active_c;
    logic             unused_ir_bits;
    ctrl_t            dec_c, ctrl_c;

    assign ir_opc_c       = IR[31:27];
    assign unused_ir_bits = ^IR[26:0];

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign trap_c = (ir_opc_c == OP_HALT) || !is_defined(ir_opc_c);
`else
    assign trap_c = (ir_opc_c == OP_HALT);
`endif

    // A stop request is remembered until the instruction in flight reaches its last step.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        opc_d       = opc_q;
        stop_pend_d = stop_pend_q | stop;
`ifdef ILLEGAL_TRAP_EN
        illegal_d   = illegal_q;
`endif
        case (state_q)
            FETCH: begin
                if (step_q == T2) begin
                    opc_d   = ir_opc_c;
                    state_d = trap_c ? HALT : EXEC;
                    step_d  = trap_c ? T0 : T3;
`ifdef ILLEGAL_TRAP_EN
                    if (!is_defined(ir_opc_c)) illegal_d = 1'b1;
`endif
                end else begin
                    step_d = step_e'(step_q + 3'd1);
                end
            end
            EXEC: begin
                if (step_q == last_step(opc_q)) begin
                    state_d     = stop_pend_d ? HALT : FETCH;
                    step_d      = T0;
                    stop_pend_d = 1'b0;
                end else begin
                    step_d = step_e'(step_q + 3'd1);
                end
            end
            HALT: begin
                step_d      = T0;
                stop_pend_d = 1'b0;
            end
            default: begin
                state_d = FETCH;
                step_d  = T0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= FETCH;
            step_q      <= T0;
            opc_q       <= '0;
            stop_pend_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            opc_q       <= opc_d;
            stop_pend_q <= stop_pend_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    ctrl_decode u_decode (
        .opc  (opc_q),
        .step (step_q),
        .con  (CON),
        .ctrl (dec_c)
    );

    // clear silences every strobe immediately, aborting any partially executed step.
    assign active_c = !clear && (state_q != HALT);
    assign ctrl_c   = active_c ? dec_c : '0;
    assign run      = active_c;
    assign step     = clear ? '0 : step_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_op = !clear && illegal_q;
`endif

    assign PCout     = ctrl_c.pc_out;
    assign MDRout    = ctrl_c.mdr_out;
    assign Zhighout  = ctrl_c.zhigh_out;
    assign Zlowout   = ctrl_c.zlow_out;
    assign HIout     = ctrl_c.hi_out;
    assign LOout     = ctrl_c.lo_out;
    assign Inportout = ctrl_c.inport_out;
    assign Cout      = ctrl_c.c_out;
    assign BAout     = ctrl_c.ba_out;
    assign PCin      = ctrl_c.pc_in;
    assign IRin      = ctrl_c.ir_in;
    assign MARin     = ctrl_c.mar_in;
    assign MDRin     = ctrl_c.mdr_in;
    assign Yin       = ctrl_c.y_in;
    assign Zin       = ctrl_c.z_in;
    assign HIin      = ctrl_c.hi_in;
    assign LOin      = ctrl_c.lo_in;
    assign OutPort   = ctrl_c.out_port;
    assign Gra       = ctrl_c.gra;
    assign Grb       = ctrl_c.grb;
    assign Grc       = ctrl_c.grc;
    assign Rin       = ctrl_c.rin;
    assign Rout      = ctrl_c.rout;
    assign read      = ctrl_c.read;
    assign write     = ctrl_c.write;
    assign AND       = ctrl_c.alu.op_and;
    assign OR        = ctrl_c.alu.op_or;
    assign ADD       = ctrl_c.alu.op_add;
    assign SUB       = ctrl_c.alu.op_sub;
    assign MUL       = ctrl_c.alu.op_mul;
    assign DIV       = ctrl_c.alu.op_div;
    assign SHR       = ctrl_c.alu.op_shr;
    assign SHL       = ctrl_c.alu.op_shl;
    assign ROR       = ctrl_c.alu.op_ror;
    assign ROL       = ctrl_c.alu.op_rol;
    assign NEG       = ctrl_c.alu.op_neg;
    assign NOT       = ctrl_c.alu.op_not;
    assign IncPC     = ctrl_c.alu.op_inc_pc;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle strobe vectors compared against hand-written tables.
module tb_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clear, stop, CON;
    logic [31:0] IR;
    logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPort;
    logic Gra, Grb, Grc, Rin, Rout, read, write;
    logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;
    logic run;
    logic [2:0] step;
`ifdef ILLEGAL_TRAP_EN
    logic illegal_op;
`endif

    control_sequencer dut (
        .clk(clk), .clear(clear), .stop(stop), .IR(IR), .CON(CON),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIout(HIout), .LOout(LOout), .Inportout(Inportout), .Cout(Cout), .BAout(BAout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .HIin(HIin), .LOin(LOin), .OutPort(OutPort),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .read(read), .write(write),
        .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
        .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT), .IncPC(IncPC),
        .run(run), .step(step)
`ifdef ILLEGAL_TRAP_EN
        , .illegal_op(illegal_op)
`endif
    );

    logic [37:0] sig;
    assign sig = {PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout,
                  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPort,
                  Gra, Grb, Grc, Rin, Rout, read, write,
                  AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC};

    localparam logic [37:0] PCOUT   = 38'h1 << 37;
    localparam logic [37:0] MDROUT  = 38'h1 << 36;
    localparam logic [37:0] ZHIOUT  = 38'h1 << 35;
    localparam logic [37:0] ZLOOUT  = 38'h1 << 34;
    localparam logic [37:0] LOOUT   = 38'h1 << 32;
    localparam logic [37:0] COUT    = 38'h1 << 30;
    localparam logic [37:0] BAOUT   = 38'h1 << 29;
    localparam logic [37:0] PCIN    = 38'h1 << 28;
    localparam logic [37:0] IRIN    = 38'h1 << 27;
    localparam logic [37:0] MARIN   = 38'h1 << 26;
    localparam logic [37:0] MDRIN   = 38'h1 << 25;
    localparam logic [37:0] YIN     = 38'h1 << 24;
    localparam logic [37:0] ZIN     = 38'h1 << 23;
    localparam logic [37:0] HIIN    = 38'h1 << 22;
    localparam logic [37:0] LOIN    = 38'h1 << 21;
    localparam logic [37:0] GRA     = 38'h1 << 19;
    localparam logic [37:0] GRB     = 38'h1 << 18;
    localparam logic [37:0] GRC     = 38'h1 << 17;
    localparam logic [37:0] RIN     = 38'h1 << 16;
    localparam logic [37:0] ROUT    = 38'h1 << 15;
    localparam logic [37:0] READ    = 38'h1 << 14;
    localparam logic [37:0] WRITE   = 38'h1 << 13;
    localparam logic [37:0] OP_ADD  = 38'h1 << 10;
    localparam logic [37:0] OP_MUL  = 38'h1 << 8;
    localparam logic [37:0] INCPC   = 38'h1 << 0;

    localparam logic [37:0] F0 = PCOUT | MARIN | INCPC | ZIN;
    localparam logic [37:0] F1 = ZLOOUT | PCIN | READ | MDRIN;
    localparam logic [37:0] F2 = MDROUT | IRIN;

    int errors = 0;
    int checks = 0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Leaves the DUT in FETCH T0 with clear low, two time units after an edge.
    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        clear = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [37:0] exp [5] = '{F0, F1, F2, 38'h0, F0};
        int          stp [5] = '{0, 1, 2, 3, 0};
        clear = 1'b1;
        IR    = 32'hC800_0000;
        #2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sig !== 38'h0 || run !== 1'b0 || step !== 3'd0) begin
                errors++;
                $display("FAIL reset_hold c%0d sig=%h run=%b step=%0d want sig=0 run=0 step=0", i, sig, run, step);
            end
            if (i < 2) tick();
        end
        clear = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            checks++;
            if (sig !== exp[i] || step !== 3'(stp[i]) || run !== 1'b1) begin
                errors++;
                $display("FAIL reset_fetch c%0d sig=%h step=%0d run=%b want sig=%h step=%0d run=1", i, sig, step, run, exp[i], stp[i]);
            end
        end
    endtask

    task automatic test_add();
        logic [37:0] exp [7] = '{F0, F1, F2, GRB | ROUT | YIN, GRC | ROUT | OP_ADD | ZIN, ZLOOUT | GRA | RIN, F0};
        int          stp [7] = '{0, 1, 2, 3, 4, 5, 0};
        IR = 32'h1891_8000;
        do_clear();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            checks++;
            if (sig !== exp[i] || step !== 3'(stp[i]) || run !== 1'b1) begin
                errors++;
                $display("FAIL add c%0d sig=%h step=%0d run=%b want sig=%h step=%0d run=1", i, sig, step, run, exp[i], stp[i]);
            end
        end
    endtask

    task automatic test_ld();
        logic [37:0] exp [9] = '{F0, F1, F2, GRB | BAOUT | YIN, COUT | OP_ADD | ZIN, ZLOOUT | MARIN,
                                 READ | MDRIN, MDROUT | GRA | RIN, F0};
        int          stp [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        IR = 32'h0090_0055;
        do_clear();
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            checks++;
            if (sig !== exp[i] || step !== 3'(stp[i]) || run !== 1'b1) begin
                errors++;
                $display("FAIL ld c%0d sig=%h step=%0d run=%b want sig=%h step=%0d run=1", i, sig, step, run, exp[i], stp[i]);
            end
        end
    endtask

    task automatic test_br();
        logic [37:0] exp [8];
        int          stp [8] = '{0, 1, 2, 3, 4, 5, 6, 0};
        IR = 32'h9000_0000;
        for (int c = 0; c < 2; c++) begin
            CON = c[0];
            exp = '{F0, F1, F2, GRA | ROUT, PCOUT | YIN, COUT | OP_ADD | ZIN,
                    (c == 1) ? (ZLOOUT | PCIN) : 38'h0, F0};
            do_clear();
            for (int i = 0; i < 8; i++) begin
                if (i > 0) tick();
                checks++;
                if (sig !== exp[i] || step !== 3'(stp[i]) || run !== 1'b1) begin
                    errors++;
                    $display("FAIL br_con%0d c%0d sig=%h step=%0d run=%b want sig=%h step=%0d run=1", c, i, sig, step, run, exp[i], stp[i]);
                end
            end
        end
        CON = 1'b0;
    endtask

    task automatic test_jr();
        logic [37:0] exp [5] = '{F0, F1, F2, GRA | ROUT | PCIN, F0};
        int          stp [5] = '{0, 1, 2, 3, 0};
        IR = 32'h9800_0000;
        do_clear();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            checks++;
            if (sig !== exp[i] || step !== 3'(stp[i]) || run !== 1'b1) begin
                errors++;
                $display("FAIL jr c%0d sig=%h step=%0d want sig=%h step=%0d", i, sig, step, exp[i], stp[i]);
            end
        end
    endtask

    task automatic test_stop();
        IR = 32'h1891_8000;
        do_clear();
        repeat (4) tick();
        checks++;
        if (sig !== (GRC | ROUT | OP_ADD | ZIN)) begin
            errors++;
            $display("FAIL stop_T4 sig=%h want %h", sig, GRC | ROUT | OP_ADD | ZIN);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (sig !== (ZLOOUT | GRA | RIN) || run !== 1'b1) begin
            errors++;
            $display("FAIL stop_T5 sig=%h run=%b want sig=%h run=1", sig, run, ZLOOUT | GRA | RIN);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (sig !== 38'h0 || run !== 1'b0 || step !== 3'd0) begin
                errors++;
                $display("FAIL stop_halt c%0d sig=%h run=%b step=%0d want all 0", i, sig, run, step);
            end
        end
    endtask

    task automatic test_halt_opcode();
        logic [37:0] exp [3] = '{F0, F1, F2};
        IR = 32'hD000_0000;
        do_clear();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            checks++;
            if (sig !== exp[i] || run !== 1'b1) begin
                errors++;
                $display("FAIL halt_fetch c%0d sig=%h run=%b want sig=%h run=1", i, sig, run, exp[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (sig !== 38'h0 || run !== 1'b0) begin
                errors++;
                $display("FAIL halt_state c%0d sig=%h run=%b want sig=0 run=0", i, sig, run);
            end
        end
    endtask

    task automatic test_undefined();
        IR = 32'hA000_0000;
        do_clear();
        repeat (3) tick();
`ifdef ILLEGAL_TRAP_EN
        checks++;
        if (sig !== 38'h0 || run !== 1'b0 || illegal_op !== 1'b1) begin
            errors++;
            $display("FAIL undef_trap sig=%h run=%b illegal_op=%b want 0/0/1", sig, run, illegal_op);
        end
`else
        checks++;
        if (sig !== 38'h0 || run !== 1'b1 || step !== 3'd3) begin
            errors++;
            $display("FAIL undef_nop sig=%h run=%b step=%0d want sig=0 run=1 step=3", sig, run, step);
        end
        tick();
        checks++;
        if (sig !== F0 || step !== 3'd0) begin
            errors++;
            $display("FAIL undef_next sig=%h step=%0d want sig=%h step=0", sig, step, F0);
        end
`endif
    endtask

    task automatic test_clear_mid_mul();
        logic [37:0] exp [6] = '{F0, F1, F2, GRA | ROUT | YIN, GRB | ROUT | OP_MUL | ZIN, ZLOOUT | LOIN};
        logic        hi_seen = 1'b0;
        IR = 32'h7000_0000;
        do_clear();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            hi_seen |= HIin;
            checks++;
            if (sig !== exp[i]) begin
                errors++;
                $display("FAIL mul c%0d sig=%h want %h", i, sig, exp[i]);
            end
        end
        clear = 1'b1;
        tick();
        hi_seen |= HIin;
        checks++;
        if (sig !== 38'h0 || run !== 1'b0) begin
            errors++;
            $display("FAIL mul_clear sig=%h run=%b want sig=0 run=0", sig, run);
        end
        clear = 1'b0;
        #1;
        hi_seen |= HIin;
        checks++;
        if (sig !== F0 || step !== 3'd0 || run !== 1'b1) begin
            errors++;
            $display("FAIL mul_refetch sig=%h step=%0d run=%b want sig=%h step=0 run=1", sig, step, run, F0);
        end
        tick();
        hi_seen |= HIin;
        checks++;
        if (sig !== F1 || hi_seen !== 1'b0) begin
            errors++;
            $display("FAIL mul_no_hiin sig=%h hi_seen=%b want sig=%h hi_seen=0", sig, hi_seen, F1);
        end
    endtask

    initial begin
        clear = 1'b1;
        stop  = 1'b0;
        CON   = 1'b0;
        IR    = 32'h0;
        test_reset();
        test_add();
        test_ld();
        test_br();
        test_jr();
        test_stop();
        test_halt_opcode();
        test_undefined();
        test_clear_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
